// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC local address map, read sequence and read FSM states
package rtc_pkg;

  localparam int NUM_BYTES = 9;

  // Local RTC register map, shared with the write-side distributor
  localparam logic [3:0] ADDR_SEG_HORA   = 4'd0;
  localparam logic [3:0] ADDR_MIN_HORA   = 4'd1;
  localparam logic [3:0] ADDR_HORA_HORA  = 4'd2;
  localparam logic [3:0] ADDR_DIA_FECHA  = 4'd3;
  localparam logic [3:0] ADDR_MES_FECHA  = 4'd4;
  localparam logic [3:0] ADDR_JAHR_FECHA = 4'd5;
  localparam logic [3:0] ADDR_DIA_SEMANA = 4'd6; // day of week: never read or written
  localparam logic [3:0] ADDR_SEG_TIMER  = 4'd7;
  localparam logic [3:0] ADDR_MIN_TIMER  = 4'd8;
  localparam logic [3:0] ADDR_HORA_TIMER = 4'd9;

  // Burst read order; entry i lands in shadow slot i
  localparam logic [3:0] RD_SEQ [NUM_BYTES] = '{
    ADDR_SEG_HORA, ADDR_MIN_HORA, ADDR_HORA_HORA,
    ADDR_DIA_FECHA, ADDR_MES_FECHA, ADDR_JAHR_FECHA,
    ADDR_SEG_TIMER, ADDR_MIN_TIMER, ADDR_HORA_TIMER
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_NEXT   = 2'd2,
    ST_COMMIT = 2'd3
  } rd_state_e;

endpackage

// File: rtl/rtc_read_distr_if.sv
// rtl/rtc_read_distr_if.sv - read channel between distributor and RTC bus driver
interface rtc_read_distr_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] out_addr_mem_local;
  logic              rd_req;
  logic              rd_ack;
  logic [7:0]        in_dato_de_rtc;

  modport master (
    output out_addr_mem_local,
    output rd_req,
    input  rd_ack,
    input  in_dato_de_rtc
  );

  modport slave (
    input  out_addr_mem_local,
    input  rd_req,
    output rd_ack,
    output in_dato_de_rtc
  );
endinterface

// File: rtl/rtc_addr_seq.sv
// rtl/rtc_addr_seq.sv - maps burst index 0..8 to local RTC address
module rtc_addr_seq
  import rtc_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [3:0]        idx_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Combinational ROM lookup; out-of-range indices map to address 0
  always_comb begin
    addr_o = '0;
    if (idx_i < 4'(NUM_BYTES)) begin
      addr_o = ADDR_W'(RD_SEQ[idx_i]);
    end
  end

endmodule

// File: rtl/rtc_read_distr.sv
// rtl/rtc_read_distr.sv - burst reader of the RTC map with atomic commit of nine bytes
module rtc_read_distr
  import rtc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_rd,
  rtc_read_distr_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       out_seg_hora,
  output logic [7:0]       out_min_hora,
  output logic [7:0]       out_hora_hora,
  output logic [7:0]       out_dia_fecha,
  output logic [7:0]       out_mes_fecha,
  output logic [7:0]       out_jahr_fecha,
  output logic [7:0]       out_seg_timer,
  output logic [7:0]       out_min_timer,
  output logic [7:0]       out_hora_timer
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      IDX_LAST = 4'(NUM_BYTES - 1);

  rd_state_e        state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       shadow_q [NUM_BYTES];
  logic [7:0]       out_q    [NUM_BYTES];
  logic             capture;
  logic             commit;
  logic [ADDR_W-1:0] seq_addr;

  rtc_addr_seq #(.ADDR_W(ADDR_W)) u_addr_seq (
    .idx_i  (idx_q),
    .addr_o (seq_addr)
  );

  // Next-state logic; err_q blocks a start arriving in the err cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_rd && !err_q) begin
          state_d = ST_REQ;
          idx_d   = '0;
        end
      end
      ST_REQ: begin
        if (bus.rd_ack) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = ST_NEXT;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          commit  = 1'b1;
          state_d = ST_COMMIT;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_REQ;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM, index, timeout counter and error pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Shadow capture of each acked byte; outputs load together so done sees the new set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      if (capture) begin
        shadow_q[idx_q] <= bus.in_dato_de_rtc;
      end
      if (commit) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          out_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign bus.rd_req             = (state_q == ST_REQ);
  assign bus.out_addr_mem_local = (state_q == ST_REQ || state_q == ST_NEXT) ? seq_addr : '0;
  assign busy                   = (state_q == ST_REQ || state_q == ST_NEXT);
  assign done                   = (state_q == ST_COMMIT);
  assign err                    = err_q;

  assign out_seg_hora   = out_q[0];
  assign out_min_hora   = out_q[1];
  assign out_hora_hora  = out_q[2];
  assign out_dia_fecha  = out_q[3];
  assign out_mes_fecha  = out_q[4];
  assign out_jahr_fecha = out_q[5];
  assign out_seg_timer  = out_q[6];
  assign out_min_timer  = out_q[7];
  assign out_hora_timer = out_q[8];

endmodule

// File: tb/tb_rtc_read_distr.sv
// tb/tb_rtc_read_distr.sv - bench for rtc_read_distr with vector table, random bursts and corner sequences
module tb_rtc_read_distr;

  localparam int T      = 255;
  localparam int ADDR_W = 4;
  localparam int MAXC   = 2000;

  typedef struct {
    logic [71:0] data;
    int          dly;
    int          hold;
    bit          spur;
    bit          exp_done;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  logic clk;
  logic reset;
  logic start_rd;
  logic busy, done, err;
  logic [7:0] out_seg_hora, out_min_hora, out_hora_hora;
  logic [7:0] out_dia_fecha, out_mes_fecha, out_jahr_fecha;
  logic [7:0] out_seg_timer, out_min_timer, out_hora_timer;

  rtc_read_distr_if #(.ADDR_W(ADDR_W)) bus ();

  rtc_read_distr #(.TIMEOUT_CYC(T), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_rd       (start_rd),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .out_seg_hora   (out_seg_hora),
    .out_min_hora   (out_min_hora),
    .out_hora_hora  (out_hora_hora),
    .out_dia_fecha  (out_dia_fecha),
    .out_mes_fecha  (out_mes_fecha),
    .out_jahr_fecha (out_jahr_fecha),
    .out_seg_timer  (out_seg_timer),
    .out_min_timer  (out_min_timer),
    .out_hora_timer (out_hora_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [71:0] exp_out;
  vec_t        vec [6];

  function automatic int exp_addr(input int i);
    return (i < 6) ? i : i + 1;
  endfunction

  function automatic logic [71:0] addr_pattern();
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(8'h10 + exp_addr(i));
    return v;
  endfunction

  function automatic logic [71:0] dut_outs();
    return {out_hora_timer, out_min_timer, out_seg_timer,
            out_jahr_fecha, out_mes_fecha, out_dia_fecha,
            out_hora_hora, out_min_hora, out_seg_hora};
  endfunction

  function automatic int lat_of(input int dly, input int hold);
    return (hold < 0) ? 9 * (dly + 2) + 1 : hold * (dly + 2) + T + 1;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic run_burst(input logic [71:0] data, input int dly, input int hold,
                           input bit spur, input bit post,
                           output bit got_done, output bit got_err, output int lat);
    logic [71:0]       old_out, new_exp;
    logic [ADDR_W-1:0] cur_addr;
    int b, w, nreq;
    bit addr_ok, stable_ok, hold_ok, busy_ok, post_ok;
    old_out = exp_out;
    new_exp = (hold < 0) ? data : exp_out;
    b = 0; w = 0; nreq = 0; cur_addr = '0;
    addr_ok = 1; stable_ok = 1; hold_ok = 1; busy_ok = 1;
    got_done = 0; got_err = 0; lat = -1;
    @(negedge clk);
    start_rd = 1'b1;
    bus.rd_ack = spur;
    bus.in_dato_de_rtc = 8'hEE;
    @(negedge clk);
    start_rd = 1'b0;
    for (int k = 1; k <= MAXC; k++) begin
      if (done || err) begin
        got_done = done; got_err = err; lat = k;
        break;
      end
      if (dut_outs() !== old_out) hold_ok = 0;
      if (busy !== 1'b1) busy_ok = 0;
      start_rd = (spur && k == 5);
      if (bus.rd_req) begin
        if (w == 0) begin
          cur_addr = bus.out_addr_mem_local;
          if (cur_addr !== ADDR_W'(exp_addr(nreq))) addr_ok = 0;
          nreq++;
        end else if (bus.out_addr_mem_local !== cur_addr) begin
          stable_ok = 0;
        end
        if (w == dly && b != hold) begin
          bus.rd_ack = 1'b1;
          bus.in_dato_de_rtc = data[b*8 +: 8];
          b++; w = 0;
        end else begin
          bus.rd_ack = 1'b0;
          w++;
        end
      end else begin
        if (w != 0) stable_ok = 0;
        w = 0;
        bus.rd_ack = spur;
        bus.in_dato_de_rtc = 8'hEE;
      end
      @(negedge clk);
    end
    start_rd = 1'b0;
    bus.rd_ack = 1'b0;
    chk("terminal_seen", 72'(got_done | got_err), 72'd1);
    chk("addr_order", 72'(addr_ok), 72'd1);
    chk("req_count", 72'(nreq), 72'((hold < 0) ? 9 : hold + 1));
    chk("req_addr_stable", 72'(stable_ok), 72'd1);
    chk("outs_hold_until_end", 72'(hold_ok), 72'd1);
    chk("busy_during_burst", 72'(busy_ok), 72'd1);
    chk("busy_at_end", 72'(busy), 72'd0);
    chk("outs_at_end", dut_outs(), new_exp);
    exp_out = new_exp;
    if (post) begin
      post_ok = 1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || bus.rd_req !== 1'b0 ||
            bus.out_addr_mem_local !== '0 || dut_outs() !== exp_out) post_ok = 0;
      end
      chk("idle_after_end", 72'(post_ok), 72'd1);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit gd, ge;
    int lat;
    run_burst(v.data, v.dly, v.hold, v.spur, 1'b1, gd, ge, lat);
    chk($sformatf("vec%0d_done", id), 72'(gd), 72'(v.exp_done));
    chk($sformatf("vec%0d_err", id), 72'(ge), 72'(v.exp_err));
    chk($sformatf("vec%0d_latency", id), 72'(lat), 72'(v.exp_lat));
  endtask

  initial begin
    bit          gd, ge, ok;
    int          lat, dly, hold, k;
    logic [95:0] r96;
    logic [71:0] d72;

    vec[0] = '{data: addr_pattern(), dly: 0, hold: -1, spur: 0,
               exp_done: 1, exp_err: 0, exp_lat: 19};
    vec[1] = '{data: {8'h01, 8'h30, 8'h00, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59},
               dly: 3, hold: -1, spur: 0, exp_done: 1, exp_err: 0, exp_lat: 46};
    vec[2] = '{data: 72'hA8A7A6A5A4A3A2A1A0, dly: 0, hold: 4, spur: 0,
               exp_done: 0, exp_err: 1, exp_lat: 264};
    vec[3] = '{data: 72'h292827262524232221, dly: 1, hold: -1, spur: 1,
               exp_done: 1, exp_err: 0, exp_lat: 28};
    vec[4] = '{data: 72'h0102030405060708FF, dly: 2, hold: 8, spur: 1,
               exp_done: 0, exp_err: 1, exp_lat: 288};
    vec[5] = '{data: 72'h5A5A5A5A5A5A5A5A5A, dly: 0, hold: 0, spur: 0,
               exp_done: 0, exp_err: 1, exp_lat: 256};

    exp_out = '0;
    reset = 1'b1;
    start_rd = 1'b0;
    bus.rd_ack = 1'b0;
    bus.in_dato_de_rtc = 8'h00;
    #1;
    chk("reset_outs", dut_outs(), 72'd0);
    chk("reset_ctrl", 72'({busy, done, err, bus.rd_req}), 72'd0);
    chk("reset_addr", 72'(bus.out_addr_mem_local), 72'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vec[i], i);

    // start_rd in the err cycle must be ignored; err lasts one cycle
    run_burst(72'h111111111111111111, 0, 2, 1'b0, 1'b0, gd, ge, lat);
    chk("errcyc_err", 72'(ge), 72'd1);
    chk("errcyc_latency", 72'(lat), 72'(lat_of(0, 2)));
    start_rd = 1'b1;
    @(negedge clk);
    start_rd = 1'b0;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || bus.rd_req !== 1'b0 || err !== 1'b0) ok = 0;
      @(negedge clk);
    end
    chk("errcyc_start_ignored", 72'(ok), 72'd1);

    // back-to-back: second start on the first IDLE cycle after done
    run_burst(72'h0F0E0D0C0B0A090807, 0, -1, 1'b0, 1'b0, gd, ge, lat);
    chk("b2b_first_latency", 72'(lat), 72'd19);
    run_burst(72'hC8C7C6C5C4C3C2C1C0, 1, -1, 1'b0, 1'b1, gd, ge, lat);
    chk("b2b_second_done", 72'(gd), 72'd1);
    chk("b2b_second_latency", 72'(lat), 72'd28);

    // asynchronous reset while byte 5 is being requested
    @(negedge clk);
    start_rd = 1'b1;
    @(negedge clk);
    start_rd = 1'b0;
    ok = 0;
    for (k = 0; k < 200; k++) begin
      if (bus.rd_req && bus.out_addr_mem_local == ADDR_W'(5)) begin
        ok = 1;
        break;
      end
      bus.rd_ack = bus.rd_req;
      bus.in_dato_de_rtc = 8'h55;
      @(negedge clk);
    end
    bus.rd_ack = 1'b0;
    chk("rst_reached_byte5", 72'(ok), 72'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_outs", dut_outs(), 72'd0);
    chk("rst_mid_ctrl", 72'({busy, done, err, bus.rd_req}), 72'd0);
    exp_out = '0;
    @(negedge clk);
    reset = 1'b0;
    run_vec(vec[0], 10);

    // randomized bursts against the reference model
    for (int r = 0; r < 8; r++) begin
      r96  = {$urandom(), $urandom(), $urandom()};
      d72  = r96[71:0];
      dly  = int'($urandom_range(0, 4));
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_burst(d72, dly, hold, 1'($urandom_range(0, 1)), 1'b1, gd, ge, lat);
      chk($sformatf("rand%0d_done", r), 72'(gd), 72'(hold < 0));
      chk($sformatf("rand%0d_latency", r), 72'(lat), 72'(lat_of(dly, hold)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_read_distr.md
Name: rtc_read_distr

Overview:
- Read-side counterpart of the RTC write-data distributor. It sequences a burst read of the local RTC register map: seconds, minutes, hours, day, month and year, plus timer seconds, minutes and hours.
- It drives address and read request to the RTC bus driver and captures each returned byte into a shadow buffer.
- When the burst completes it commits all nine bytes to the output registers at once, so the display and control logic never see a torn time/date.
- Sits between the RTC bus-timing driver and the display/edit logic.

Parameters:
- TIMEOUT_CYC, 255, max clk cycles to wait for rd_ack per byte before aborting (8-bit counter width covers the default).
- ADDR_W, 4, width of local address bus.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start_rd  in  1  one-cycle pulse; begin a burst read
- rd_ack  in  1  bus driver: in_dato_de_rtc valid this cycle
- in_dato_de_rtc  in  8  byte read from RTC (BCD, passed through unchanged)
- out_addr_mem_local  out  ADDR_W  local address of byte being read
- rd_req  out  1  read request to bus driver
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse: burst committed
- err  out  1  one-cycle pulse: timeout abort, no commit
- out_seg_hora, out_min_hora, out_hora_hora  out  8 each  committed time
- out_dia_fecha, out_mes_fecha, out_jahr_fecha  out  8 each  committed date
- out_seg_timer, out_min_timer, out_hora_timer  out  8 each  committed timer

Behaviour:
- Reset (async): FSM=IDLE; every output, shadow byte, index and timeout counter = 0.
- Address sequence: 0,1,2,3,4,5,7,8,9. Address 6 (day of week) is skipped. Byte i of the sequence goes to shadow slot i (9 slots).
- FSM states: IDLE, REQ, NEXT, COMMIT.
- IDLE:
  - start_rd=1 -> REQ with index=0 and busy=1.
  - rd_req=0.
- REQ:
  - rd_req=1; out_addr_mem_local = seq[index], held stable while rd_req=1; timeout counter increments each cycle.
  - rd_ack=1 -> capture in_dato_de_rtc into shadow[index] that same edge, clear counter, go to NEXT. rd_req drops in the cycle after ack.
  - counter reaches TIMEOUT_CYC with no ack -> err pulse, busy=0, go to IDLE. Outputs keep their previous values.
- NEXT (1 cycle, rd_req=0):
  - index==8 -> COMMIT.
  - otherwise index+1 -> REQ.
- COMMIT (1 cycle):
  - all nine outputs load from shadow simultaneously; done=1; busy=0; -> IDLE.
- Latency: with zero-wait ack (ack in first REQ cycle), the burst takes 9 x 2 cycles + 1 COMMIT = 19 cycles from the start_rd edge to done.
- rd_ack outside REQ: ignored, nothing captured.
- start_rd while busy: ignored, no restart or queueing.
- start_rd in the same cycle as done/err: ignored; a new start needs a pulse once back in IDLE.
- Reset mid-burst: immediate return to IDLE; outputs cleared to 0, including previously committed values.
- out_addr_mem_local in IDLE: 0.

Decomposition:
- Shared package rtc_pkg:
  - address constants ADDR_SEG_HORA=0 .. ADDR_HORA_TIMER=9, and ADDR_DIA_SEMANA=6 marked unused.
  - read-sequence table.
  - FSM state encoding.
- The write-side distributor uses the same address constants.
- One natural sub-module: rtc_addr_seq, which maps index 0..8 to the local address (combinational ROM).
- Shadow buffer and commit stay in the top module.

Test Plan:
- Zero-wait burst:
  - Stimulus: start_rd pulse; bench acks every request immediately with data = 0x10 + address.
  - Required: address order 0,1,2,3,4,5,7,8,9. On the done pulse (cycle 19): out_seg_hora=0x10, out_jahr_fecha=0x15, out_seg_timer=0x17, out_hora_timer=0x19.
- Wait states:
  - Stimulus: ack delayed 3 cycles per byte, data 0x59,0x59,0x23,0x31,0x12,0x99,0x00,0x30,0x01.
  - Required: rd_req and address stay stable during each wait. Outputs stay at old values until done, then all update in the same cycle.
- Timeout:
  - Stimulus: after a good burst, start again and withhold ack at byte 4 (address 4).
  - Required: err pulses exactly TIMEOUT_CYC cycles after that REQ entry. No done pulse. All outputs retain the previous burst's values. busy=0.
- Ignored inputs:
  - Stimulus: extra start_rd at cycle 5 of a burst; spurious rd_ack while in IDLE and in NEXT.
  - Required: a single burst completes normally with exactly one done pulse; nothing is captured from the spurious acks.
- Reset mid-burst:
  - Stimulus: assert reset asynchronously during byte 5, between clock edges.
  - Required: all outputs, rd_req and busy go to 0 immediately. After release, a new start_rd runs a full clean burst.
- Back-to-back:
  - Stimulus: start_rd on the first IDLE cycle after done.
  - Required: second burst starts at address 0 and commits its own data.
